// File: rtl/cpu_types_pkg.sv
// Shared CPU bus types: RAM status encoding and the 32-bit word.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/mem_arb_wdog.sv
// Saturating stall counter for the memory arbiter. 'expired' is high in the
// cycle whose increment makes the count reach MAX.
module mem_arb_wdog #(
    parameter int MAX = 255
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] count;

    assign expired = inc && (count == W'(MAX - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != W'(MAX))) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Memory-side arbiter between icache and dcache onto a single-ported RAM.
// Define MEM_ARB_RR_EN to alternate grants under contention (default: dcache priority).
module mem_arbiter #(
    parameter int WDOG_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        busy,
    output logic        wdog_err
);

    import cpu_types_pkg::*;

    typedef enum logic [1:0] {IDLE, DXFER, IXFER} arb_state_t;

    arb_state_t state;
    logic       d_req;
    logic       grant_req;
    logic       access;
    logic       done;
    logic       prefer_i;
    logic       wdog_clear;
    logic       wdog_inc;
    logic       wdog_expired;

    assign d_req  = dREN | dWEN;
    assign access = (ramstate_t'(ramstate) == ACCESS);

    always_comb begin
        grant_req = 1'b0;
        case (state)
            DXFER:   grant_req = d_req;
            IXFER:   grant_req = iREN;
            default: grant_req = 1'b0;
        endcase
    end

    // A withdrawn request ends the transfer without completing it.
    assign done       = grant_req && access;
    assign wdog_clear = (state == IDLE) || done;
    assign wdog_inc   = (state != IDLE) && grant_req && !access;

    mem_arb_wdog #(.MAX(WDOG_CYCLES)) u_wdog (
        .CLK     (CLK),
        .nRST    (nRST),
        .clear   (wdog_clear),
        .inc     (wdog_inc),
        .expired (wdog_expired)
    );

`ifdef MEM_ARB_RR_EN
    logic last_was_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_was_d <= 1'b0;
        end else if (done) begin
            last_was_d <= (state == DXFER);
        end
    end

    assign prefer_i = last_was_d;
`else
    assign prefer_i = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            wdog_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iREN && (!d_req || prefer_i)) begin
                        state <= IXFER;
                    end else if (d_req) begin
                        state <= DXFER;
                    end
                end
                default: begin
                    if (!grant_req || done) begin
                        state <= IDLE;
                    end else if (wdog_expired) begin
                        state    <= IDLE;
                        wdog_err <= 1'b1;
                    end
                end
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        case (state)
            DXFER: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (done) begin
                    dwait = 1'b0;
                    if (!dWEN) dload = ramload;
                end
            end
            IXFER: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (done) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic against a transaction-owner reference model.
module tb_mem_arbiter;

    localparam int WDOG = 4;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, busy, wdog_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the RAM (0 none, 1 dcache, 2 icache),
    // how long the current transfer has stalled, sticky error, RR history.
    int owner  = 0;
    int stall  = 0;
    bit err    = 1'b0;
    bit last_d = 1'b0;

    mem_arbiter #(.WDOG_CYCLES(WDOG)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .busy(busy), .wdog_err(wdog_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner  = 0;
        stall  = 0;
        err    = 1'b0;
        last_d = 1'b0;
    endtask

    task automatic compare_model();
        logic [31:0] e_addr = '0, e_store = '0, e_iload = '0, e_dload = '0;
        logic        e_ren = 1'b0, e_wen = 1'b0, e_iwait = 1'b1, e_dwait = 1'b1;
        bit          fin;
        if (owner == 1) begin
            e_addr  = daddr;
            e_store = dstore;
            e_wen   = dWEN;
            e_ren   = dREN && !dWEN;
            fin     = (dREN || dWEN) && (ramstate == 2'd2);
            e_dwait = !fin;
            if (fin && !dWEN) e_dload = ramload;
        end else if (owner == 2) begin
            e_addr  = iaddr;
            e_ren   = 1'b1;
            fin     = iREN && (ramstate == 2'd2);
            e_iwait = !fin;
            if (fin) e_iload = ramload;
        end
        check("busy",     busy,     owner != 0);
        check("ramREN",   ramREN,   e_ren);
        check("ramWEN",   ramWEN,   e_wen);
        check("ramaddr",  ramaddr,  e_addr);
        check("ramstore", ramstore, e_store);
        check("iwait",    iwait,    e_iwait);
        check("dwait",    dwait,    e_dwait);
        check("iload",    iload,    e_iload);
        check("dload",    dload,    e_dload);
        check("wdog_err", wdog_err, err);
    endtask

    // Advance the model across one rising edge using the inputs held during the cycle.
    task automatic model_step();
        bit dq = dREN || dWEN;
        bit rq;
        if (owner == 0) begin
            if (iREN && (!dq || (RR && last_d))) begin
                owner = 2; stall = 0;
            end else if (dq) begin
                owner = 1; stall = 0;
            end
        end else begin
            rq = (owner == 1) ? dq : iREN;
            if (!rq) begin
                owner = 0;
            end else if (ramstate == 2'd2) begin
                last_d = (owner == 1);
                owner  = 0;
            end else begin
                stall++;
                if (stall >= WDOG) begin
                    err   = 1'b1;
                    owner = 0;
                end
            end
        end
    endtask

    task automatic sample();
        @(negedge CLK);
        compare_model();
    endtask

    task automatic advance();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    task automatic idle_inputs();
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = 2'd0;
    endtask

    initial begin
        nRST = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        check("rst_iwait", iwait, 1);
        check("rst_dwait", dwait, 1);
        check("rst_busy",  busy,  0);
        check("rst_err",   wdog_err, 0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        cyc();

        // Icache fetch with two BUSY cycles before ACCESS.
        iREN = 1; iaddr = 32'h40; ramstate = 2'd1;
        sample(); check("t1_c1_busy", busy, 0); advance();
        sample(); check("t1_c2_busy", busy, 1); check("t1_c2_addr", ramaddr, 32'h40); advance();
        sample(); check("t1_c3_iwait", iwait, 1); advance();
        ramstate = 2'd2; ramload = 32'hDEADBEEF;
        sample(); check("t1_c4_iwait", iwait, 0); check("t1_c4_iload", iload, 32'hDEADBEEF);
        advance();
        iREN = 0; ramstate = 2'd0;
        sample(); check("t1_c5_busy", busy, 0); advance();

        // Write and fetch together: dcache first, then icache after the bubble.
        dWEN = 1; daddr = 32'h3100; dstore = 32'h7; iREN = 1; iaddr = 32'h44; ramstate = 2'd2;
        cyc();
        sample(); check("t2_wen", ramWEN, 1); check("t2_store", ramstore, 32'h7); check("t2_dwait", dwait, 0);
        advance();
        dWEN = 0;
        sample(); check("t2_bubble", busy, 0); advance();
        sample(); check("t2_iaddr", ramaddr, 32'h44); check("t2_iwait", iwait, 0);
        advance();
        iREN = 0;
        cyc();

        // Contention: streaming dcache reads against a held icache request.
        dREN = 1; daddr = 32'h100; iREN = 1; iaddr = 32'h200; ramstate = 2'd2; ramload = 32'h55;
        for (int k = 0; k < 4; k++) begin
            cyc();
            sample();
            check("rr_grant", ramaddr, (RR && (k % 2 == 1)) ? 32'h200 : 32'h100);
            advance();
        end
        dREN = 0;
        cyc();
        sample(); check("rr_i_after_d", ramaddr, 32'h200); advance();
        iREN = 0;
        cyc();

        // Granted dREN withdrawn after one BUSY cycle; pending icache follows.
        dREN = 1; daddr = 32'h500; iREN = 1; iaddr = 32'h600; ramstate = 2'd1;
        cyc();
        sample(); check("wd_d_busy", busy, 1); check("wd_d_ren", ramREN, 1); advance();
        dREN = 0;
        sample(); check("wd_no_dwait", dwait, 1); advance();
        sample(); check("wd_idle", busy, 0); advance();
        ramstate = 2'd2;
        sample(); check("wd_i_addr", ramaddr, 32'h600); check("wd_i_iwait", iwait, 0); advance();
        iREN = 0;
        cyc();

        // Watchdog: RAM stuck in ERROR.
        dREN = 1; daddr = 32'h700; ramstate = 2'd3;
        cyc();
        for (int k = 0; k < WDOG; k++) begin
            sample(); check("wdg_dwait", dwait, 1); check("wdg_err_low", wdog_err, 0);
            check("wdg_busy", busy, 1);
            advance();
        end
        sample(); check("wdg_err_set", wdog_err, 1); check("wdg_idle", busy, 0); advance();
        ramstate = 2'd2;
        sample(); check("wdg_regrant", busy, 1); check("wdg_done", dwait, 0); advance();
        dREN = 0;
        cyc();

        // Asynchronous reset in the middle of an icache fetch.
        iREN = 1; iaddr = 32'h800; ramstate = 2'd1;
        cyc();
        sample(); check("rs_busy", busy, 1);
        ramstate = 2'd2; ramload = 32'hCAFE0001;
        #1;
        check("rs_pre_iload", iload, 32'hCAFE0001);
        check("rs_pre_iwait", iwait, 0);
        nRST = 1'b0;
        #1;
        check("rs_ramREN", ramREN, 0);
        check("rs_busy0",  busy,   0);
        check("rs_iload",  iload,  0);
        check("rs_iwait",  iwait,  1);
        check("rs_err",    wdog_err, 0);
        model_reset();
        @(posedge CLK); #1;
        nRST = 1'b1; ramstate = 2'd1;
        sample(); check("rs_idle", busy, 0); advance();
        sample(); check("rs_regrant", ramaddr, 32'h800); advance();
        iREN = 0;
        cyc();

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            iREN     = ($urandom_range(99) < 50);
            dREN     = ($urandom_range(99) < 35);
            dWEN     = ($urandom_range(99) < 20);
            iaddr    = $urandom;
            daddr    = $urandom;
            dstore   = $urandom;
            ramload  = $urandom;
            ramstate = 2'($urandom_range(3));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Memory-side responder for the cache bus: accepts instruction-fetch requests from the icache and read/write requests from the dcache, grants one at a time to the single-ported RAM, and returns data with per-requester wait handshakes. It is the other end of the `dREN`/`dWEN`/`daddr`/`dstore`/`dwait`/`dload` protocol the caches drive. It sits between the cache pair and the RAM model, with a registered grant FSM and a watchdog on stalled RAM accesses.

## Interface
- `WDOG_CYCLES`, default 255: number of consecutive non-ACCESS cycles in a transfer after which the transfer is abandoned.
- `CLK`  in  1  clock, rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `iREN`  in  1  icache read request.
- `iaddr`  in  32  icache word address.
- `iwait`  out  1  low for exactly the cycle `iload` is valid.
- `iload`  out  32  instruction word.
- `dREN`  in  1  dcache read request.
- `dWEN`  in  1  dcache write request.
- `daddr`  in  32  dcache word address.
- `dstore`  in  32  dcache write data.
- `dwait`  out  1  low for exactly the cycle the dcache access completes.
- `dload`  out  32  data word.
- `ramREN`  out  1  RAM read strobe.
- `ramWEN`  out  1  RAM write strobe.
- `ramaddr`  out  32  RAM address.
- `ramstore`  out  32  RAM write data.
- `ramload`  in  32  RAM read data.
- `ramstate`  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- `busy`  out  1  high while in DXFER or IXFER.
- `wdog_err`  out  1  sticky; set on a watchdog expiry; cleared only by reset.

## Operation
- States are IDLE, DXFER and IXFER. Reset puts the FSM in IDLE.
- Reset values:
  - `iwait` = `dwait` = 1.
  - `iload` = `dload` = 0.
  - `ramREN` = `ramWEN` = 0, `ramaddr` = `ramstore` = 0.
  - `busy` = 0, `wdog_err` = 0, watchdog count = 0.
- IDLE:
  - Drives no RAM strobes.
  - If `dREN` or `dWEN` is high, next state is DXFER.
  - Else if `iREN` is high, next state is IXFER.
  - Else the FSM stays in IDLE.
- DXFER drives the RAM from the live dcache signals:
  - `ramaddr` = `daddr`, `ramstore` = `dstore`.
  - `ramWEN` = `dWEN`, `ramREN` = `dREN & ~dWEN`; write wins if both are high.
- IXFER drives `ramaddr` = `iaddr`, `ramREN` = 1, `ramWEN` = 0.
- Completion: in XFER with `ramstate` == ACCESS:
  - The granted wait goes low.
  - On a read, the granted load = `ramload`; the other load stays 0.
  - Next state is IDLE.
- `ramstate` == ERROR or BUSY: the FSM stays in XFER, keeps driving, and the watchdog increments.
- Watchdog:
  - The count is cleared on entry to XFER and on completion.
  - When the count reaches `WDOG_CYCLES`, `wdog_err` is set, the FSM returns to IDLE, and the wait stays high.
  - The requester is re-arbitrated normally.
- Request withdrawn while granted (relevant request bit low in XFER): abort to IDLE with no wait pulse and no watchdog effect.
- Loads are combinational from `ramload`; only the FSM state, the watchdog count, `wdog_err` and the RR flag are registered.

## Timing
- Request seen in IDLE at cycle N → RAM strobes asserted in cycle N+1.
- Earliest completion is cycle N+1, when `ramstate` is ACCESS in the same cycle.
- Minimum 2 cycles per transaction, because of the IDLE bubble between back-to-back transfers.
  - A dcache two-word block fill therefore takes at least 4 cycles.
- A wait is low for exactly one cycle per completed transaction. The requester must hold its request, address and data stable until then.
- Simultaneous `iREN` and `dREN` in IDLE: data wins, except as modified under Configuration.
- Reset asserted mid-transfer: outputs return to reset values immediately (asynchronously); the in-flight access is dropped.
- Watchdog expiry: `wdog_err` rises on the edge where the count equals `WDOG_CYCLES`. IDLE is entered on that same edge.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - A 1-bit `last_was_d` flag is set on a DXFER completion and cleared on an IXFER completion.
  - In IDLE with both requests pending and `last_was_d` = 1, IXFER is granted.
  - The effect is alternating grants under contention.
- Not defined: fixed dcache priority and no flag; the icache can starve while the dcache streams.

## Structure
- `ramstate_t` (FREE/BUSY/ACCESS/ERROR) and `word_t` come from `cpu_types_pkg`.
- The arbiter state enum is local to the module.
- One sub-module, `mem_arb_wdog`:
  - Parameterised saturating counter with `clear`/`inc` inputs and an `expired` output.
  - Reset to 0 asynchronously on `nRST`.

## Test plan
- `iREN`=1, `iaddr`=0x40, RAM returns ACCESS after 2 BUSY cycles with `ramload`=0xDEADBEEF → `iwait` low for 1 cycle at cycle 4 with `iload`=0xDEADBEEF; `busy` high for cycles 2–4.
- `dWEN`=1, `daddr`=0x3100, `dstore`=0x7 together with `iREN`=1 → DXFER first (`ramWEN`=1, `ramstore`=7), then IXFER after the IDLE bubble.
- `MEM_ARB_RR_EN` defined, dcache issuing continuous reads and `iREN` held high → grants alternate D, I, D, I; without the macro, the I request is granted only after the D requests stop.
- `ramstate` held at ERROR with `WDOG_CYCLES`=4 → `wdog_err` rises 4 cycles after entering DXFER, FSM returns to IDLE, `dwait` never drops, then re-grant.
- `nRST` pulsed low during IXFER → `ramREN`, `busy` and `iload` read 0 and `iwait` reads 1 immediately; after release, a fresh IDLE grant occurs.
- Granted `dREN` dropped after one BUSY cycle → return to IDLE with no `dwait` pulse; a pending `iREN` is granted next.
